// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the mux_pipe_n pipelined select stage.
package mux_pipe_pkg;
  localparam int MODE_EXT = 0;
  localparam int MODE_RR  = 1;
  localparam int BEAT_W   = 16;

  // Select width: clog2(n), never less than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_pipe_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr, with wrap.
module mux_pipe_rr_pick
  import mux_pipe_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  int idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int off = NUM_IN; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_IN;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// N-way WIDTH-bit registered select stage with valid/ready handshake.
// Define MUX_PIPE_SKID_EN to add a skid entry that registers in_ready.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  parameter int MODE   = 0,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEAT_W-1:0]       beat_cnt
);

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   pick_data;
  logic               ready_term;
  logic               accept;
  logic               drain;
  logic [WIDTH-1:0]   chan_data [NUM_IN];

  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [SEL_W-1:0]   out_chan_reg;
  logic [BEAT_W-1:0]  beat_cnt_reg;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr_reg;

      mux_pipe_rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
        .req      (in_valid),
        .ptr      (ptr_reg),
        .gnt_valid(pick_valid),
        .gnt_idx  (pick_idx)
      );

      // Pointer moves only on an accepted beat so stalls keep fairness order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ptr_reg <= SEL_W'(NUM_IN - 1);
        else if (accept)
          ptr_reg <= pick_idx;
      end
    end else begin : g_ext
      assign pick_valid = (int'(sel) < NUM_IN);
      assign pick_idx   = sel;
    end
  endgenerate

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi]  = pick_valid && (pick_idx == SEL_W'(gi)) && ready_term;
  end

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (pick_idx == SEL_W'(k))
        pick_data = chan_data[k];
  end

  assign accept = |(in_valid & in_ready);
  assign drain  = out_valid_reg && out_ready;

`ifdef MUX_PIPE_SKID_EN
  logic             skid_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic [SEL_W-1:0] skid_chan_reg;

  // Registered ready: two entries of storage absorb the out_ready round trip.
  assign ready_term = !(out_valid_reg && skid_valid_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_chan_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_chan_reg  <= '0;
    end else if (!out_valid_reg) begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= pick_data;
        out_chan_reg  <= pick_idx;
      end
    end else if (drain) begin
      if (skid_valid_reg) begin
        out_data_reg <= skid_data_reg;
        out_chan_reg <= skid_chan_reg;
        if (accept) begin
          skid_data_reg <= pick_data;
          skid_chan_reg <= pick_idx;
        end else begin
          skid_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        out_data_reg <= pick_data;
        out_chan_reg <= pick_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= pick_data;
      skid_chan_reg  <= pick_idx;
    end
  end
`else
  assign ready_term = !out_valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= pick_data;
      out_chan_reg  <= pick_idx;
    end else if (drain) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_cnt_reg <= '0;
    else if (drain)
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench: external-select instance (6 ch) and round-robin instance (8 ch).
module tb_mux_pipe_n;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [6*16-1:0] a_in_data;
  logic [5:0]      a_in_valid, a_in_ready;
  logic [2:0]      a_sel, a_out_chan;
  logic [15:0]     a_out_data, a_beat_cnt;
  logic            a_out_valid, a_out_ready;

  logic [8*16-1:0] b_in_data;
  logic [7:0]      b_in_valid, b_in_ready;
  logic [2:0]      b_sel, b_out_chan;
  logic [15:0]     b_out_data, b_beat_cnt;
  logic            b_out_valid, b_out_ready;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  mux_pipe_n #(.WIDTH(16), .NUM_IN(6), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .beat_cnt(a_beat_cnt)
  );

  mux_pipe_n #(.WIDTH(16), .NUM_IN(8), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .beat_cnt(b_beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) b_in_data[k*16 +: 16] = 16'hB000 + 16'(k);
    step; step;
    rst_n = 1'b1;

    check("rst a_out_valid", 32'(a_out_valid), 0);
    check("rst a_out_data",  32'(a_out_data), 0);
    check("rst a_out_chan",  32'(a_out_chan), 0);
    check("rst a_beat_cnt",  32'(a_beat_cnt), 0);
    check("rst b_out_valid", 32'(b_out_valid), 0);
    check("rst b_beat_cnt",  32'(b_beat_cnt), 0);

    // Test 1: external select of channel 3
    a_sel = 3'd3; a_in_valid = 6'b001000; a_in_data[3*16 +: 16] = 16'hA5A5;
    #1 check("t1 in_ready", 32'(a_in_ready), 32'h08);
    step;
    check("t1 out_valid", 32'(a_out_valid), 1);
    check("t1 out_data",  32'(a_out_data), 32'hA5A5);
    check("t1 out_chan",  32'(a_out_chan), 3);
    a_in_valid = '0;
    step;
    check("t1 drained", 32'(a_out_valid), 0);
    check("t1 beat_cnt", 32'(a_beat_cnt), 1);

    // Test 4: out-of-range select picks nothing
    a_sel = 3'd7; a_in_valid = 6'b111111;
    #1 check("t4 in_ready", 32'(a_in_ready), 0);
    step; step;
    check("t4 out_valid", 32'(a_out_valid), 0);
    check("t4 beat_cnt", 32'(a_beat_cnt), 1);

    // Test 3: backpressure on channel 1
    a_in_valid = 6'b000010; a_sel = 3'd1; a_out_ready = 1'b0;
    a_in_data[1*16 +: 16] = 16'h1111;
    exp_q.delete();
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
`ifdef MUX_PIPE_SKID_EN
    exp_q.push_back(16'h3333);
`endif
    step;
    a_in_data[1*16 +: 16] = 16'h2222;
`ifdef MUX_PIPE_SKID_EN
    #1 check("t3 ready after 1", 32'(a_in_ready), 32'h02);
    step;
    a_in_data[1*16 +: 16] = 16'h3333;
`else
    #1 check("t3 ready after 1", 32'(a_in_ready), 0);
    step;
`endif
    check("t3 ready full", 32'(a_in_ready), 0);
    for (int c = 0; c < 4; c++) begin
      check("t3 hold data", 32'(a_out_data), 32'h1111);
      check("t3 hold chan", 32'(a_out_chan), 1);
      step;
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check("t3 drain valid", 32'(a_out_valid), 1);
      check("t3 drain data", 32'(a_out_data), 32'(exp_q[i]));
      step;
      if (i == exp_q.size() - 2) a_in_valid = '0;
    end
    check("t3 empty", 32'(a_out_valid), 0);
    check("t3 beat_cnt", 32'(a_beat_cnt), 32'(1 + exp_q.size()));

    // Test 2: round robin over all eight channels
    b_in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step;
      check("t2 chan", 32'(b_out_chan), 32'(i % 8));
      check("t2 data", 32'(b_out_data), 32'(16'hB000 + 16'(i % 8)));
    end
    b_in_valid = '0;
    step;
    check("t2 empty", 32'(b_out_valid), 0);
    check("t2 beat_cnt", 32'(b_beat_cnt), 9);

    // Test 5: channels 2 and 6 alternate, stall in between
    b_in_valid = 8'b0100_0100;
    step; check("t5 chan a", 32'(b_out_chan), 2);
    step; check("t5 chan b", 32'(b_out_chan), 6);
    b_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      check("t5 stall chan", 32'(b_out_chan), 6);
      check("t5 stall data", 32'(b_out_data), 32'hB006);
    end
    b_out_ready = 1'b1;
    step; check("t5 chan c", 32'(b_out_chan), 2);
    step; check("t5 chan d", 32'(b_out_chan), 6);
    step; check("t5 chan e", 32'(b_out_chan), 2);
    b_in_valid = '0;
    step;
    check("t5 empty", 32'(b_out_valid), 0);

    // Test 6: reset mid-stream, pointer returns to channel 0 first
    b_in_valid = 8'hFF;
    step; check("t6 pre chan", 32'(b_out_chan), 3);
    step; check("t6 pre chan2", 32'(b_out_chan), 4);
    rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", 32'(b_out_valid), 0);
    check("t6 rst beat_cnt",  32'(b_beat_cnt), 0);
    check("t6 rst a_beat_cnt", 32'(a_beat_cnt), 0);
    step;
    rst_n = 1'b1;
    step;
    check("t6 post valid", 32'(b_out_valid), 1);
    check("t6 post chan",  32'(b_out_chan), 0);
    check("t6 post data",  32'(b_out_data), 32'hB000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
